// File: rtl/a2d_arb.sv
// Shares A2D_intf between cmd_cfg battery requests (priority) and a periodic channel scan; grant 1 clk after request, results 1 clk after a2d_cnv_cmplt.
// No backpressure: request pulses are held in pending flags until granted, and every output is a registered one-clock pulse or held value.
module a2d_arb #(
    parameter logic [15:0] SCAN_PERIOD     = 16'd50000,
    parameter int          NUM_SCAN_CH     = 3,
    parameter logic [2:0]  BATT_CH         = 3'd0,
    parameter logic [7:0]  LOW_BATT_THRESH = 8'hC0,
    parameter logic [11:0] TIMEOUT         = 12'd4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_strt_cnv,
    output logic        cmd_cnv_cmplt,
    output logic [7:0]  batt,
    output logic        a2d_strt_cnv,
    output logic [2:0]  a2d_chnnl,
    input  logic        a2d_cnv_cmplt,
    input  logic [11:0] a2d_res,
    output logic        scan_vld,
    output logic [2:0]  scan_chnnl,
    output logic [11:0] scan_res,
    output logic        low_batt,
    output logic        a2d_err
);
    localparam logic [2:0] LAST_CH = 3'(NUM_SCAN_CH - 1);

    typedef enum logic [1:0] {IDLE, CONV_CMD, CONV_SCAN} state_t;

    state_t      state;
    logic [15:0] timer;
    logic [11:0] wdog;
    logic [2:0]  scan_ptr;
    logic        cmd_pend;
    logic        scan_pend;
    logic        low_cnt;
    logic        expire;
    logic        cmd_req;
    logic        scan_req;
    logic        grant_cmd;
    logic        grant_scan;
    logic        wdog_hit;
    logic [2:0]  ptr_nxt;

    // The raw pulse joins the pending flag so an idle grant costs no extra clock.
    always_comb begin
        expire     = (timer == SCAN_PERIOD - 16'd1);
        cmd_req    = cmd_pend | cmd_strt_cnv;
        scan_req   = scan_pend | expire;
        grant_cmd  = (state == IDLE) && cmd_req;
        grant_scan = (state == IDLE) && !cmd_req && scan_req;
        wdog_hit   = (wdog == TIMEOUT);
        ptr_nxt    = (scan_ptr == LAST_CH) ? 3'd0 : scan_ptr + 3'd1;
    end

    // A pulse coinciding with a grant of an already-pending request stays latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= 16'd0;
            cmd_pend  <= 1'b0;
            scan_pend <= 1'b0;
        end else begin
            timer     <= expire ? 16'd0 : timer + 16'd1;
            cmd_pend  <= cmd_strt_cnv ? !(grant_cmd && !cmd_pend) : (cmd_pend && !grant_cmd);
            scan_pend <= expire ? !(grant_scan && !scan_pend) : (scan_pend && !grant_scan);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wdog          <= 12'd0;
            scan_ptr      <= 3'd0;
            low_cnt       <= 1'b0;
            cmd_cnv_cmplt <= 1'b0;
            batt          <= 8'h00;
            a2d_strt_cnv  <= 1'b0;
            a2d_chnnl     <= 3'd0;
            scan_vld      <= 1'b0;
            scan_chnnl    <= 3'd0;
            scan_res      <= 12'h000;
            low_batt      <= 1'b0;
            a2d_err       <= 1'b0;
        end else begin
            cmd_cnv_cmplt <= 1'b0;
            a2d_strt_cnv  <= 1'b0;
            scan_vld      <= 1'b0;
            a2d_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cmd) begin
                        state        <= CONV_CMD;
                        a2d_strt_cnv <= 1'b1;
                        a2d_chnnl    <= BATT_CH;
                        wdog         <= 12'd0;
                    end else if (grant_scan) begin
                        state        <= CONV_SCAN;
                        a2d_strt_cnv <= 1'b1;
                        a2d_chnnl    <= scan_ptr;
                        wdog         <= 12'd0;
                    end
                end
                CONV_CMD: begin
                    if (a2d_cnv_cmplt) begin
                        batt          <= a2d_res[11:4];
                        cmd_cnv_cmplt <= 1'b1;
                        state         <= IDLE;
                    end else if (wdog_hit) begin
                        batt          <= 8'h00;
                        cmd_cnv_cmplt <= 1'b1;
                        a2d_err       <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wdog <= wdog + 12'd1;
                    end
                end
                CONV_SCAN: begin
                    if (a2d_cnv_cmplt) begin
                        scan_res   <= a2d_res;
                        scan_chnnl <= a2d_chnnl;
                        scan_vld   <= 1'b1;
                        scan_ptr   <= ptr_nxt;
                        state      <= IDLE;
                        if (a2d_chnnl == BATT_CH) begin
                            if (a2d_res[11:4] < LOW_BATT_THRESH) begin
                                if (low_cnt)
                                    low_batt <= 1'b1;
                                low_cnt <= 1'b1;
                            end else begin
                                low_cnt <= 1'b0;
                            end
                        end
                    end else if (wdog_hit) begin
                        a2d_err  <= 1'b1;
                        scan_ptr <= ptr_nxt;
                        state    <= IDLE;
                    end else begin
                        wdog <= wdog + 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_arb.sv
// Bench for a2d_arb: behavioural A2D responder plus scoreboard queues for command, scan and error results.
module tb_a2d_arb;
    localparam int TO_CLKS = 20;
    localparam int PERIOD  = 100;

    typedef struct {
        logic [7:0] batt;
        bit         tmo;
    } cmd_exp_t;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] res;
        int          vcyc;
    } scan_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_strt_cnv;
    logic        cmd_cnv_cmplt;
    logic [7:0]  batt;
    logic        a2d_strt_cnv;
    logic [2:0]  a2d_chnnl;
    logic        a2d_cnv_cmplt;
    logic [11:0] a2d_res;
    logic        scan_vld;
    logic [2:0]  scan_chnnl;
    logic [11:0] scan_res;
    logic        low_batt;
    logic        a2d_err;

    int          cyc = 0;
    int          r0 = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          last_strt = 0;
    int          last_cmplt = 0;
    bit          withhold = 1'b0;
    logic [11:0] ch_val [8];

    cmd_exp_t    cmd_q  [$];
    scan_exp_t   scan_q [$];
    int          err_q  [$];

    a2d_arb #(
        .SCAN_PERIOD    (16'd100),
        .NUM_SCAN_CH    (3),
        .BATT_CH        (3'd0),
        .LOW_BATT_THRESH(8'hC0),
        .TIMEOUT        (12'd20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_strt_cnv (cmd_strt_cnv),
        .cmd_cnv_cmplt(cmd_cnv_cmplt),
        .batt         (batt),
        .a2d_strt_cnv (a2d_strt_cnv),
        .a2d_chnnl    (a2d_chnnl),
        .a2d_cnv_cmplt(a2d_cnv_cmplt),
        .a2d_res      (a2d_res),
        .scan_vld     (scan_vld),
        .scan_chnnl   (scan_chnnl),
        .scan_res     (scan_res),
        .low_batt     (low_batt),
        .a2d_err      (a2d_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rel();
        return cyc - r0;
    endfunction

    // Scan completion cycles; scans 1 and 17 are delayed behind a command conversion.
    function automatic int exp_vld(input int n);
        if (n == 1)
            return 243;
        if (n == 17)
            return 1824;
        return 121 + PERIOD * n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, rel());
    endtask

    task automatic wait_until(input int c);
        while (rel() < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_cmd(input int c);
        wait_until(c);
        cmd_strt_cnv = 1'b1;
        @(posedge clk);
        #1;
        cmd_strt_cnv = 1'b0;
    endtask

    task automatic push_cmd(input logic [7:0] b, input bit tmo);
        cmd_exp_t e;
        e.batt = b;
        e.tmo  = tmo;
        cmd_q.push_back(e);
    endtask

    task automatic wait_start(input string tag, input int exp_cyc, input logic [2:0] exp_ch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = a2d_strt_cnv;
        end
        if (seen) begin
            chk({tag, "_cyc"}, rel(), exp_cyc);
            chk({tag, "_ch"}, 32'(a2d_chnnl), 32'(exp_ch));
        end else begin
            chk({tag, "_no_start"}, 32'd0, 32'd1);
        end
    endtask

    // Behavioural converter: answers 20 clocks after a start, or 30 when withheld.
    initial begin : a2d_model
        logic [2:0] mch;
        int         mdly;
        a2d_cnv_cmplt = 1'b0;
        a2d_res       = 12'h000;
        forever begin
            @(negedge clk);
            if (rst_n && a2d_strt_cnv) begin
                mch  = a2d_chnnl;
                mdly = withhold ? 30 : 20;
                repeat (mdly) @(posedge clk);
                #1;
                a2d_cnv_cmplt = 1'b1;
                a2d_res       = ch_val[mch];
                last_cmplt    = rel();
                @(posedge clk);
                #1;
                a2d_cnv_cmplt = 1'b0;
                a2d_res       = 12'h000;
            end
        end
    end

    initial begin : monitor
        cmd_exp_t  ce;
        scan_exp_t se;
        int        n;
        int        ecyc;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (a2d_strt_cnv)
                    last_strt = rel();
                if (cmd_cnv_cmplt) begin
                    if (cmd_q.size() == 0) begin
                        chk("cmd_extra", 32'd1, 32'd0);
                    end else begin
                        ce = cmd_q.pop_front();
                        chk("cmd_batt", 32'(batt), 32'(ce.batt));
                        chk("cmd_lat", rel(), ce.tmo ? last_strt + TO_CLKS + 1 : last_cmplt + 1);
                    end
                end
                if (scan_vld) begin
                    if (scan_q.size() == 0) begin
                        chk("scan_extra", 32'd1, 32'd0);
                    end else begin
                        se = scan_q.pop_front();
                        chk("scan_ch", 32'(scan_chnnl), 32'(se.ch));
                        chk("scan_res", 32'(scan_res), 32'(se.res));
                        chk("scan_cyc", rel(), se.vcyc);
                    end
                end
                if (a2d_err) begin
                    if (err_q.size() == 0) begin
                        chk("err_extra", 32'd1, 32'd0);
                    end else begin
                        ecyc = err_q.pop_front();
                        chk("err_cyc", rel(), ecyc);
                    end
                end
                if (rel() >= PERIOD - 1 && (rel() - (PERIOD - 1)) % PERIOD == 0) begin
                    n       = (rel() - (PERIOD - 1)) / PERIOD;
                    se.ch   = 3'(n % 3);
                    se.res  = ch_val[se.ch];
                    se.vcyc = exp_vld(n);
                    scan_q.push_back(se);
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        cmd_strt_cnv = 1'b0;
        for (int i = 0; i < 8; i++)
            ch_val[i] = 12'h000;
        ch_val[0] = 12'hD00;
        ch_val[1] = 12'h123;
        ch_val[2] = 12'h456;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_cnv_cmplt", 32'(cmd_cnv_cmplt), 32'd0);
        chk("rst_batt", 32'(batt), 32'd0);
        chk("rst_a2d_strt_cnv", 32'(a2d_strt_cnv), 32'd0);
        chk("rst_a2d_chnnl", 32'(a2d_chnnl), 32'd0);
        chk("rst_scan_vld", 32'(scan_vld), 32'd0);
        chk("rst_scan_chnnl", 32'(scan_chnnl), 32'd0);
        chk("rst_scan_res", 32'(scan_res), 32'd0);
        chk("rst_low_batt", 32'(low_batt), 32'd0);
        chk("rst_a2d_err", 32'(a2d_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0    = cyc;

        // Single command
        ch_val[0] = 12'hAB7;
        push_cmd(8'hAB, 1'b0);
        pulse_cmd(20);
        wait_start("single", 21, 3'd0);
        wait_until(50);
        ch_val[0] = 12'hD00;

        // Command coincides with the second timer expiry (scan_ptr=1)
        push_cmd(8'hD0, 1'b0);
        pulse_cmd(199);
        wait_start("prio_cmd", 200, 3'd0);
        wait_start("prio_scan", 222, 3'd1);

        // Two command pulses during a scan conversion merge into one
        push_cmd(8'hD0, 1'b0);
        pulse_cmd(305);
        pulse_cmd(310);
        wait_start("merge_cmd", 322, 3'd0);

        // Low-battery filter on BATT_CH scans 3, 6, 9, 12, 15
        wait_until(350);
        ch_val[0] = 12'hBF0;
        wait_until(425);
        chk("lowb_after_bf0", 32'(low_batt), 32'd0);
        wait_until(440);
        ch_val[0] = 12'hB00;
        push_cmd(8'hB0, 1'b0);
        pulse_cmd(450);
        wait_start("cmd_low", 451, 3'd0);
        wait_until(480);
        ch_val[0] = 12'hC00;
        wait_until(490);
        chk("lowb_cmd_ignored", 32'(low_batt), 32'd0);
        wait_until(725);
        chk("lowb_after_c00", 32'(low_batt), 32'd0);
        wait_until(750);
        ch_val[0] = 12'hBF0;
        wait_until(1025);
        chk("lowb_after_bf0_2", 32'(low_batt), 32'd0);
        wait_until(1050);
        ch_val[0] = 12'hBE0;
        wait_until(1325);
        chk("lowb_after_be0", 32'(low_batt), 32'd1);
        wait_until(1350);
        ch_val[0] = 12'hFF0;
        wait_until(1625);
        chk("lowb_sticky", 32'(low_batt), 32'd1);

        // Watchdog: converter answers too late, then a normal command
        wait_until(1725);
        withhold = 1'b1;
        push_cmd(8'h00, 1'b1);
        err_q.push_back(1731 + TO_CLKS + 1);
        pulse_cmd(1730);
        wait_start("tmo_cmd", 1731, 3'd0);
        wait_until(1770);
        withhold = 1'b0;
        push_cmd(8'hFF, 1'b0);
        pulse_cmd(1780);
        wait_start("after_tmo", 1781, 3'd0);

        wait_until(1860);
        chk("cmd_q_left", cmd_q.size(), 32'd0);
        chk("scan_q_left", scan_q.size(), 32'd0);
        chk("err_q_left", err_q.size(), 32'd0);
        chk("lowb_final", 32'(low_batt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
